clk_period_monitor: RTL
=======================

Name: clk_period_monitor

Overview:
Measures the period of a slow, divider-generated clock, such as the variable divided clock from the clock/reset block. It samples that clock as asynchronous data in the fast system clock domain and counts system-clock cycles between rising edges. Each result is checked against an expected period, and the block keeps min/max/sample statistics and flags a stuck clock. It sits downstream of the clock/reset block as the bring-up and self-check consumer of its divided clock output.

Parameters:
COUNT_W, 16, width of period counter and all period/statistic outputs
SYNC_STAGES, 2, synchronizer flops on meas_clk_in (legal range 2-4)
TIMEOUT_CYCLES, 4096, cycles with no rising edge before stuck_out asserts (must be < 2^COUNT_W)
TOL, 0, allowed |period - expected| before mismatch is flagged

Ports:
clk_in  input  1  system clock (fast domain; meas clock must be at most clk_in/4)
rst_low_in  input  1  asynchronous active-low reset
meas_clk_in  input  1  clock under measurement, asynchronous to clk_in
enable_in  input  1  run measurement; low returns the FSM to IDLE
clear_in  input  1  single-cycle pulse; clears statistics and sticky flags
expected_period_in  input  COUNT_W  expected period in clk_in cycles; 0 disables the check
period_out  output  COUNT_W  last measured period
period_valid_out  output  1  one-cycle pulse when period_out updates
min_period_out  output  COUNT_W  minimum period since clear
max_period_out  output  COUNT_W  maximum period since clear
sample_cnt_out  output  COUNT_W  number of measurements since clear; saturates at all-ones
mismatch_out  output  1  sticky flag: a measurement was outside expected ± TOL
stuck_out  output  1  no edge for TIMEOUT_CYCLES; clears on the next edge

Behaviour:
- Reset (asynchronous, active-low):
  - sync chain = 0 and edge-history flop = 0.
  - State = IDLE; counters = 0.
  - period_out = 0, period_valid_out = 0, max_period_out = 0, min_period_out = all-ones, sample_cnt_out = 0, mismatch_out = 0, stuck_out = 0.
- Synchronizer and edge detect:
  - meas_clk_in passes through SYNC_STAGES flops.
  - edge = synced & ~prev, where prev is one further flop.
  - edge is a one-cycle pulse, SYNC_STAGES+1 cycles after the raw rising edge.
- FSM states:
  - IDLE:
    - cnt = 0; outputs hold.
    - enable_in = 1 → ARM next cycle.
  - ARM (waiting for the first edge):
    - cnt increments each cycle.
    - On edge: cnt ← 1, stuck_out ← 0, go to MEASURE. No result is produced, because the first edge only starts a partial period.
  - MEASURE:
    - cnt increments each cycle.
    - On edge: period_out ← cnt, period_valid_out = 1 the following cycle, cnt ← 1, statistics updated.
- Timeout (ARM or MEASURE):
  - If cnt reaches TIMEOUT_CYCLES with no edge: stuck_out ← 1, cnt ← 0, state ← ARM, no sample recorded.
  - If an edge and the timeout occur in the same cycle, the edge wins.
- Statistics update on each measurement P:
  - min ← min(min, P); max ← max(max, P); sample_cnt ← sample_cnt + 1, saturating.
  - If expected_period_in ≠ 0 and |P − expected| > TOL: mismatch_out ← 1 (sticky). Compute the difference with an unsigned compare, without wrap.
- clear_in:
  - min ← all-ones, max ← 0, sample_cnt ← 0, mismatch ← 0, stuck ← 0.
  - If clear_in coincides with a measurement, the clear is applied first and the sample is then folded in: min = max = P, count = 1, mismatch evaluated on P only.
- enable_in deasserted in any state:
  - IDLE next cycle; any partial period is discarded.
  - Statistics and flags hold; period_valid_out does not pulse.
  - Re-enable restarts in ARM.
- cnt saturates at all-ones. It cannot overflow when TIMEOUT_CYCLES < 2^COUNT_W.
- Reset asserted mid-measurement returns everything to the reset values immediately (asynchronous).
- expected_period_in is sampled at the measurement cycle. Changing it never retroactively sets or clears mismatch.

Test Plan:
1. Bench parameters TIMEOUT_CYCLES=64, TOL=0. meas clock 5 high/5 low, expected 10, enable → first period_valid_out pulse after the second synced edge; period_out=10, min=max=10, mismatch_out=0; sample_cnt_out increments on every later edge.
2. Same clock, expected 12 → mismatch_out=1 at the first valid. Change the clock to period 12 → mismatch_out stays 1. Pulse clear_in → mismatch_out=0, sample_cnt_out=0, min=all-ones, max=0.
3. Hold meas_clk_in low after enable → stuck_out=1 exactly 64 cycles after ARM entry, with no valid pulse. Resume toggling → stuck_out=0 on the first edge; the first period_out is reported at the second edge.
4. Periods alternating 8 and 14, expected 0 → min_period_out=8, max_period_out=14, mismatch_out never set.
5. Drop enable_in mid-period, then re-enable → no valid pulse for the partial period; the next reported period is a full period. Assert rst_low_in mid-MEASURE → all outputs return to their reset values in the same cycle.
6. clear_in on the same cycle as a measurement of 9 → min=max=9, sample_cnt_out=1.

Source files
------------

// File: rtl/clk_period_monitor.sv
// Measures the period of a slow asynchronous clock in clk_in cycles, checks it
// against an expected value and keeps min/max/count statistics plus a stuck flag.
module clk_period_monitor #(
    parameter int COUNT_W        = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TOL            = 0
) (
    input  logic               clk_in,
    input  logic               rst_low_in,
    input  logic               meas_clk_in,
    input  logic               enable_in,
    input  logic               clear_in,
    input  logic [COUNT_W-1:0] expected_period_in,
    output logic [COUNT_W-1:0] period_out,
    output logic               period_valid_out,
    output logic [COUNT_W-1:0] min_period_out,
    output logic [COUNT_W-1:0] max_period_out,
    output logic [COUNT_W-1:0] sample_cnt_out,
    output logic               mismatch_out,
    output logic               stuck_out
);

    localparam logic [COUNT_W-1:0] TO_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] TOL_W   = COUNT_W'(TOL);
    localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

    state_t               r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 r_prev;
    logic [COUNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                 w_edge, w_meas, w_timeout, w_restart;

    logic [COUNT_W-1:0]   r_period, r_min, r_max, r_samples;
    logic                 r_valid, r_mismatch, r_stuck;
    logic [COUNT_W-1:0]   w_min_base, w_max_base, w_samp_base, w_diff;
    logic                 w_mis_base, w_off;

    // Synchronizer; prev is one flop past the last stage for rising-edge detect
    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], meas_clk_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + ONE;

    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Timeout fires on the cycle cnt would reach TIMEOUT_CYCLES; an edge wins
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_meas      = 1'b0;
        w_timeout   = 1'b0;
        w_restart   = 1'b0;
        if (!enable_in) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ARM;
                end
                S_ARM, S_MEAS: begin
                    if (w_edge) begin
                        w_meas      = (r_state == S_MEAS);
                        w_restart   = 1'b1;
                        w_cnt_nxt   = ONE;
                        w_state_nxt = S_MEAS;
                    end else if (r_cnt >= TO_LAST) begin
                        w_timeout   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_ARM;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A clear on the measurement cycle is applied first, then the sample folds in
    assign w_min_base  = clear_in ? '1 : r_min;
    assign w_max_base  = clear_in ? '0 : r_max;
    assign w_samp_base = clear_in ? '0 : r_samples;
    assign w_mis_base  = clear_in ? 1'b0 : r_mismatch;
    assign w_diff      = (r_cnt >= expected_period_in) ? (r_cnt - expected_period_in)
                                                       : (expected_period_in - r_cnt);
    assign w_off       = (expected_period_in != '0) && (w_diff > TOL_W);

    always_ff @(posedge clk_in or negedge rst_low_in) begin
        if (!rst_low_in) begin
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_min      <= '1;
            r_max      <= '0;
            r_samples  <= '0;
            r_mismatch <= 1'b0;
            r_stuck    <= 1'b0;
        end else begin
            r_valid <= w_meas;
            if (w_meas) begin
                r_period   <= r_cnt;
                r_min      <= (r_cnt < w_min_base) ? r_cnt : w_min_base;
                r_max      <= (r_cnt > w_max_base) ? r_cnt : w_max_base;
                r_samples  <= (w_samp_base == '1) ? w_samp_base : w_samp_base + ONE;
                r_mismatch <= w_mis_base | w_off;
            end else begin
                r_min      <= w_min_base;
                r_max      <= w_max_base;
                r_samples  <= w_samp_base;
                r_mismatch <= w_mis_base;
            end
            if (w_restart)
                r_stuck <= 1'b0;
            else if (w_timeout)
                r_stuck <= 1'b1;
            else if (clear_in)
                r_stuck <= 1'b0;
        end
    end

    assign period_out       = r_period;
    assign period_valid_out = r_valid;
    assign min_period_out   = r_min;
    assign max_period_out   = r_max;
    assign sample_cnt_out   = r_samples;
    assign mismatch_out     = r_mismatch;
    assign stuck_out        = r_stuck;

endmodule
